// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
// muldiv_seq: iterative multiply/divide unit for the execute stage.
// One shift-add (multiply) or restore (divide) step per RUN cycle over a
// shared 2*SIZE working register; signed ops run on magnitudes and fix the
// sign when the result is registered.
module muldiv_seq #(
   parameter int SIZE = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE-1:0] result,
   output logic            stall,
   output logic            done,
   output logic            busy
);

   localparam logic [2:0] OP_MUL   = 3'd0;
   localparam logic [2:0] OP_UMULH = 3'd1;
   localparam logic [2:0] OP_SMULH = 3'd2;
   localparam logic [2:0] OP_UDIV  = 3'd3;
   localparam logic [2:0] OP_SDIV  = 3'd4;
   localparam int         CW       = $clog2(SIZE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [CW-1:0]       count;
   logic [2:0]          op_reg;
   logic [SIZE-1:0]     mcand;      // multiplicand, or divisor for divides
   logic [2*SIZE-1:0]   prod;       // product, or {remainder, dividend/quotient}
   logic                neg;        // result must be negated at the end
   logic                armed;

   logic                accept;
   logic                short_path;
   logic                signed_op;
   logic                last_iter;
   logic                is_div;
   logic [SIZE-1:0]     a_mag;
   logic [SIZE-1:0]     b_mag;

   logic [SIZE:0]       mul_sum;
   logic [SIZE:0]       rem_shift;
   logic                rem_ge;
   logic [SIZE-1:0]     rem_sub;
   logic [2*SIZE-1:0]   prod_step;
   logic [SIZE-1:0]     step_hi;
   logic [SIZE-1:0]     step_lo;
   logic [SIZE-1:0]     neg_hi;
   logic [SIZE-1:0]     res_final;

   assign accept     = (state == IDLE) && start && armed;
   // Divide by zero and reserved opcodes bypass RUN and return zero.
   assign short_path = ((op == OP_UDIV) || (op == OP_SDIV)) ? (b == '0) : (op > OP_SDIV);
   assign signed_op  = (op == OP_SMULH) || (op == OP_SDIV);
   assign last_iter  = (state == RUN) && (count == CW'(SIZE - 1));
   assign is_div     = (op_reg == OP_UDIV) || (op_reg == OP_SDIV);
   assign a_mag      = a[SIZE-1] ? -a : a;
   assign b_mag      = b[SIZE-1] ? -b : b;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = short_path ? FIN : RUN;
         RUN:  if (last_iter) state_next = FIN;
         FIN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Pipeline hold: from the accept cycle through the last RUN cycle
   always_comb begin
      stall = ((state == IDLE) && start && armed) || (state == RUN) || ((state == FIN) && !done);
   end

   // One iteration step; multiply shifts right, divide shifts left
   always_comb begin
      mul_sum   = {1'b0, prod[2*SIZE-1:SIZE]} + {1'b0, mcand};
      rem_shift = prod[2*SIZE-1:SIZE-1];
      rem_ge    = rem_shift >= {1'b0, mcand};
      // The true difference is below the divisor, so SIZE bits suffice.
      rem_sub   = rem_shift[SIZE-1:0] - mcand;
      if (is_div) begin
         prod_step = rem_ge ? {rem_sub, prod[SIZE-2:0], 1'b1}
                            : {rem_shift[SIZE-1:0], prod[SIZE-2:0], 1'b0};
      end else begin
         prod_step = prod[0] ? {mul_sum, prod[SIZE-1:1]}
                             : {1'b0, prod[2*SIZE-1:1]};
      end
   end

   // Result selection and sign fix-up from the final step value
   always_comb begin
      step_hi   = prod_step[2*SIZE-1:SIZE];
      step_lo   = prod_step[SIZE-1:0];
      // Upper half of the 2*SIZE negation: carry enters only if the low half is zero.
      neg_hi    = ~step_hi + SIZE'(step_lo == '0);
      res_final = '0;
      case (op_reg)
         OP_MUL:   res_final = step_lo;
         OP_UMULH: res_final = step_hi;
         OP_SMULH: res_final = neg ? neg_hi : step_hi;
         OP_UDIV:  res_final = step_lo;
         OP_SDIV:  res_final = neg ? -step_lo : step_lo;
         default:  res_final = '0;
      endcase
   end

   // Operand latch, iteration registers, handshake and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         op_reg <= '0;
         mcand  <= '0;
         prod   <= '0;
         neg    <= 1'b0;
         armed  <= 1'b1;
         done   <= 1'b0;
         busy   <= 1'b0;
         result <= '0;
      end else begin
         if (accept) begin
            armed <= 1'b0;
         end else if (!start) begin
            armed <= 1'b1;
         end

         if (accept) begin
            op_reg <= op;
            mcand  <= signed_op ? b_mag : b;
            prod   <= {{SIZE{1'b0}}, (signed_op ? a_mag : a)};
            neg    <= signed_op && (a[SIZE-1] ^ b[SIZE-1]);
            count  <= '0;
         end else if (state == RUN) begin
            prod  <= prod_step;
            count <= count + 1'b1;
         end

         done <= (accept && short_path) || last_iter;
         busy <= (state_next == RUN) || (state_next == FIN);

         if (accept && short_path) begin
            result <= '0;
         end else if (last_iter) begin
            result <= res_final;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
// tb_muldiv_seq: directed vector table, handshake/reset sequences and
// randomized operations checked against a plain-arithmetic reference model.
module tb_muldiv_seq;

   localparam int          SIZE = 64;
   localparam logic [63:0] MIN  = 64'h8000000000000000;
   localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [63:0] a;
   logic [63:0] b;
   logic [63:0] result;
   logic        stall;
   logic        done;
   logic        busy;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [2:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[17];

   muldiv_seq #(.SIZE(SIZE)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .op(op),
      .a(a),
      .b(b),
      .result(result),
      .stall(stall),
      .done(done),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference: wide arithmetic products and language division.
   function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
      logic [127:0]        up;
      logic signed [127:0] sp;
      logic signed [63:0]  sq;
      up = {64'd0, x} * {64'd0, y};
      sp = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y});
      case (o)
         3'd0: return up[63:0];
         3'd1: return up[127:64];
         3'd2: return sp[127:64];
         3'd3: return (y == 64'd0) ? 64'd0 : x / y;
         3'd4: begin
            if (y == 64'd0) return 64'd0;
            if (x == MIN && y == ONES) return MIN;
            sq = $signed(x) / $signed(y);
            return sq;
         end
         default: return 64'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] o, input logic [63:0] y);
      if (o > 3'd4) return 1;
      if ((o == 3'd3 || o == 3'd4) && y == 64'd0) return 1;
      return SIZE + 1;
   endfunction

   // Launch one op (caller is at posedge+1, unit idle and armed) and follow it to done.
   task automatic do_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                        input logic [63:0] exp_res, input int exp_lat);
      int lat;
      int bad;
      logic [63:0] prev;
      lat  = -1;
      bad  = 0;
      prev = result;
      op = o; a = x; b = y; start = 1'b1;
      #1;
      check("accept_stall", 64'(stall), 64'd1);
      for (int c = 1; c <= SIZE + 10; c++) begin
         @(posedge clk); #1;
         if (c == 1) begin
            start = 1'b0;
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            op = 3'($urandom_range(0, 7));
         end
         if (done) begin
            lat = c;
            break;
         end
         if (stall !== 1'b1 || busy !== 1'b1 || result !== prev) bad++;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("result", result, exp_res);
      check("done_stall", 64'(stall), 64'd0);
      check("done_busy", 64'(busy), 64'd1);
      check("run_stall_busy_hold", 64'(bad), 64'd0);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("idle_busy", 64'(busy), 64'd0);
      $display("[TB] op=%0d a=%h b=%h result=%h expected=%h latency=%0d", o, x, y, result, exp_res, lat);
   endtask

   initial begin
      int pulses;
      int lat;
      logic [2:0]  ro;
      logic [63:0] rx;
      logic [63:0] ry;

      vecs[0]  = '{3'd0, 64'd3, ONES, 64'hFFFFFFFFFFFFFFFD, 65};
      vecs[1]  = '{3'd1, ONES, ONES, 64'hFFFFFFFFFFFFFFFE, 65};
      vecs[2]  = '{3'd2, ONES, ONES, 64'd0, 65};
      vecs[3]  = '{3'd4, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65};
      vecs[4]  = '{3'd4, MIN, ONES, MIN, 65};
      vecs[5]  = '{3'd3, 64'd100, 64'd0, 64'd0, 1};
      vecs[6]  = '{3'd3, 64'd100, 64'd7, 64'd14, 65};
      vecs[7]  = '{3'd5, 64'd12, 64'd3, 64'd0, 1};
      vecs[8]  = '{3'd4, 64'd7, 64'd0, 64'd0, 1};
      vecs[9]  = '{3'd2, 64'hFFFFFFFFFFFFFFFD, 64'd5, ONES, 65};
      vecs[10] = '{3'd1, 64'h100000000, 64'h100000000, 64'd1, 65};
      vecs[11] = '{3'd0, 64'h100000000, 64'h100000000, 64'd0, 65};
      vecs[12] = '{3'd4, 64'd7, 64'hFFFFFFFFFFFFFFFE, 64'hFFFFFFFFFFFFFFFD, 65};
      vecs[13] = '{3'd7, 64'd1, 64'd1, 64'd0, 1};
      vecs[14] = '{3'd3, ONES, 64'd1, ONES, 65};
      vecs[15] = '{3'd2, MIN, MIN, 64'h4000000000000000, 65};
      vecs[16] = '{3'd2, MIN, 64'd1, ONES, 65};

      // Reset state
      reset = 1'b1; start = 1'b0; op = 3'd0; a = 64'd0; b = 64'd0;
      #2 reset = 1'b0;
      #10;
      check("reset_result", result, 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_stall", 64'(stall), 64'd0);
      #1 reset = 1'b1;
      @(posedge clk); #1;

      // Directed vector table
      for (int i = 0; i < 17; i++) begin
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
      end

      // start held high: exactly one operation
      op = 3'd0; a = 64'd5; b = 64'd6; start = 1'b1;
      pulses = 0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("held_start_pulses", 64'(pulses), 64'd1);
      check("held_start_result", result, 64'd30);
      $display("[TB] held start: done pulses=%0d result=%h", pulses, result);
      start = 1'b0;
      @(posedge clk); #1;
      // one low cycle re-arms; next request is accepted
      do_op(3'd3, 64'd100, 64'd7, 64'd14, 65);

      // start pulsed during RUN is ignored
      op = 3'd0; a = 64'd7; b = 64'd9; start = 1'b1;
      pulses = 0;
      lat = -1;
      for (int c = 1; c <= 150; c++) begin
         @(posedge clk); #1;
         if (c == 1) start = 1'b0;
         if (c == 10) begin
            start = 1'b1; op = 3'd3; a = 64'd100; b = 64'd0;
         end
         if (c == 11) start = 1'b0;
         if (done) begin
            pulses++;
            if (lat < 0) lat = c;
         end
      end
      check("run_pulse_dones", 64'(pulses), 64'd1);
      check("run_pulse_latency", 64'(lat), 64'd65);
      check("run_pulse_result", result, 64'd63);
      $display("[TB] start pulse in RUN: done pulses=%0d latency=%0d result=%h", pulses, lat, result);

      // Asynchronous reset in the middle of RUN
      op = 3'd0; a = 64'd3; b = ONES; start = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (c == 1) start = 1'b0;
      end
      #3 reset = 1'b0;
      #1;
      check("async_rst_stall", 64'(stall), 64'd0);
      check("async_rst_busy", 64'(busy), 64'd0);
      check("async_rst_done", 64'(done), 64'd0);
      check("async_rst_result", result, 64'd0);
      $display("[TB] async reset mid-RUN: stall=%b busy=%b done=%b result=%h", stall, busy, done, result);
      #1 reset = 1'b1;
      // first edge after release accepts (latency 65 from that edge)
      do_op(3'd3, 64'd100, 64'd7, 64'd14, 65);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         ro = 3'($urandom_range(0, 5));
         rx = {$urandom, $urandom};
         ry = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ry = 64'($urandom_range(0, 20));
         if ($urandom_range(0, 3) == 0) rx = {{32{rx[63]}}, rx[31:0]};
         if ($urandom_range(0, 7) == 0) ry = 64'd0;
         do_op(ro, rx, ry, ref_model(ro, rx, ry), ref_lat(ro, ry));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
